// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package fetch_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH     = 9;
    localparam int DEFAULT_INSTRUCTION_WIDTH = 32;

    // addi x0, x0, 0 -- the canonical RISC-V NOP used to fill bubbles
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: holds the fetched PC, instruction word and valid flag.
module if_id_register
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = DEFAULT_ADDRESS_WIDTH,
    parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         bubble,
    input  logic [ADDRESS_WIDTH-1:0]     pc_in,
    input  logic [INSTRUCTION_WIDTH-1:0] instr_in,
    output logic [ADDRESS_WIDTH-1:0]     pc,
    output logic [INSTRUCTION_WIDTH-1:0] instr,
    output logic                         valid
);

    localparam logic [INSTRUCTION_WIDTH-1:0] NOP_WORD = INSTRUCTION_WIDTH'(NOP_INSTR);

    // Bubble wins over load so a redirect can never let a wrong-path word through.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            pc    <= '0;
            instr <= NOP_WORD;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= pc_in;
            instr <= instr_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control, fetch counter and IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH     = DEFAULT_ADDRESS_WIDTH,
    parameter int                       INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Stall,
    input  logic                         BranchTaken,
    input  logic [ADDRESS_WIDTH-1:0]     BranchTarget,
    input  logic [INSTRUCTION_WIDTH-1:0] InstrIn,
    output logic [ADDRESS_WIDTH-1:0]     PCAddress,
    output logic [ADDRESS_WIDTH-1:0]     IfIdPC,
    output logic [INSTRUCTION_WIDTH-1:0] IfIdInstr,
    output logic                         IfIdValid,
    output logic                         Fault,
    output logic [31:0]                  FetchCount
);

    fetch_state_t               state;
    fetch_state_t               state_next;
    logic [ADDRESS_WIDTH-1:0]   pc;
    logic [ADDRESS_WIDTH-1:0]   pc_next;
    logic                       fault;
    logic                       fault_next;
    logic [31:0]                fetch_count;
    logic [31:0]                fetch_count_next;
    logic                       ifid_load;
    logic                       ifid_bubble;
    logic                       misaligned_branch;

    assign misaligned_branch = BranchTaken && is_misaligned(BranchTarget[1:0]);

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        fault_next       = fault;
        fetch_count_next = fetch_count;
        ifid_load        = 1'b0;
        ifid_bubble      = 1'b0;
        unique case (state)
            BOOT: begin
                state_next  = RUN;
                ifid_bubble = 1'b1;
            end
            RUN: begin
                if (misaligned_branch) begin
                    state_next  = HALT;
                    fault_next  = 1'b1;
                    ifid_bubble = 1'b1;
                end else if (BranchTaken) begin
                    // Redirect overrides Stall: the stalled IF/ID content is wrong-path anyway.
                    pc_next     = BranchTarget;
                    ifid_bubble = 1'b1;
                end else if (!Stall) begin
                    pc_next          = pc + ADDRESS_WIDTH'(4);
                    fetch_count_next = fetch_count + 32'd1;
                    ifid_load        = 1'b1;
                end
            end
            HALT: begin
                ifid_bubble = 1'b1;
            end
            default: begin
                state_next  = BOOT;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            fault       <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            fault       <= fault_next;
            fetch_count <= fetch_count_next;
        end
    end

    if_id_register #(
        .ADDRESS_WIDTH     (ADDRESS_WIDTH),
        .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .pc_in    (pc),
        .instr_in (InstrIn),
        .pc       (IfIdPC),
        .instr    (IfIdInstr),
        .valid    (IfIdValid)
    );

    assign PCAddress  = pc;
    assign Fault      = fault;
    assign FetchCount = fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle model pushes expected outputs, compared after each edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        BranchTaken;
    logic [8:0]  BranchTarget;
    logic [31:0] InstrIn;
    logic [8:0]  PCAddress;
    logic [8:0]  IfIdPC;
    logic [31:0] IfIdInstr;
    logic        IfIdValid;
    logic        Fault;
    logic [31:0] FetchCount;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [8:0]  pc;
        logic [8:0]  ifpc;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (0=BOOT, 1=RUN, 2=HALT)
    int          m_state = 0;
    logic [8:0]  m_pc    = '0;
    logic [8:0]  m_ifpc  = '0;
    logic [31:0] m_instr = NOP;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic [31:0] m_cnt   = '0;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .InstrIn      (InstrIn),
        .PCAddress    (PCAddress),
        .IfIdPC       (IfIdPC),
        .IfIdInstr    (IfIdInstr),
        .IfIdValid    (IfIdValid),
        .Fault        (Fault),
        .FetchCount   (FetchCount)
    );

    always #5 clk = ~clk;

    // Instruction memory stand-in: word encodes the address it was read from
    always_comb InstrIn = 32'hAAAA0000 + {23'd0, PCAddress};

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_bubble();
        m_ifpc  = '0;
        m_instr = NOP;
        m_valid = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic s, input logic b, input logic [8:0] t);
        if (r) begin
            m_state = 0;
            m_pc    = '0;
            m_fault = 1'b0;
            m_cnt   = '0;
            model_bubble();
        end else if (m_state == 0) begin
            m_state = 1;
            model_bubble();
        end else if (m_state == 2) begin
            model_bubble();
        end else if (b && t[1:0] != 2'b00) begin
            m_state = 2;
            m_fault = 1'b1;
            model_bubble();
        end else if (b) begin
            m_pc = t;
            model_bubble();
        end else if (!s) begin
            m_ifpc  = m_pc;
            m_instr = 32'hAAAA0000 + {23'd0, m_pc};
            m_valid = 1'b1;
            m_pc    = m_pc + 9'd4;
            m_cnt   = m_cnt + 32'd1;
        end
    endtask

    task automatic step(input string tag, input logic r, input logic s, input logic b,
                        input logic [8:0] t);
        exp_t e;
        reset        = r;
        Stall        = s;
        BranchTaken  = b;
        BranchTarget = t;
        model_edge(r, s, b, t);
        e = '{pc: m_pc, ifpc: m_ifpc, instr: m_instr, valid: m_valid, fault: m_fault, cnt: m_cnt};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".pc"},    64'(PCAddress),  64'(e.pc));
        chk({tag, ".ifpc"},  64'(IfIdPC),     64'(e.ifpc));
        chk({tag, ".instr"}, 64'(IfIdInstr),  64'(e.instr));
        chk({tag, ".valid"}, 64'(IfIdValid),  64'(e.valid));
        chk({tag, ".fault"}, 64'(Fault),      64'(e.fault));
        chk({tag, ".cnt"},   64'(FetchCount), 64'(e.cnt));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".pc"},    64'(PCAddress),  64'h0);
        chk({tag, ".ifpc"},  64'(IfIdPC),     64'h0);
        chk({tag, ".instr"}, 64'(IfIdInstr),  64'(NOP));
        chk({tag, ".valid"}, 64'(IfIdValid),  64'h0);
        chk({tag, ".fault"}, 64'(Fault),      64'h0);
        chk({tag, ".cnt"},   64'(FetchCount), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then four fetch cycles: BOOT bubble, then PCs 0,4,8
        step("rst0", 1, 0, 0, 9'h000);
        chk_reset_values("rst0_abs");
        step("boot", 0, 0, 0, 9'h000);
        chk("boot.valid_abs", 64'(IfIdValid), 64'h0);
        for (int i = 0; i < 3; i++) step("run", 0, 0, 0, 9'h000);
        chk("s1.ifpc_abs",  64'(IfIdPC),     64'h008);
        chk("s1.instr_abs", 64'(IfIdInstr),  64'hAAAA0008);
        chk("s1.cnt_abs",   64'(FetchCount), 64'd3);

        // Stall three cycles with PC at 0x008
        step("rst1", 1, 0, 0, 9'h000);
        step("boot1", 0, 0, 0, 9'h000);
        step("f0", 0, 0, 0, 9'h000);
        step("f4", 0, 0, 0, 9'h000);
        chk("s2.pc_pre", 64'(PCAddress), 64'h008);
        for (int i = 0; i < 3; i++) step("stall", 0, 1, 0, 9'h000);
        chk("s2.pc_abs",   64'(PCAddress),  64'h008);
        chk("s2.ifpc_abs", 64'(IfIdPC),     64'h004);
        chk("s2.cnt_abs",  64'(FetchCount), 64'd2);

        // Aligned branch while stalled, then normal fetch at target
        step("br40", 0, 1, 1, 9'h040);
        chk("s3.pc_abs",    64'(PCAddress), 64'h040);
        chk("s3.instr_abs", 64'(IfIdInstr), 64'(NOP));
        chk("s3.cnt_abs",   64'(FetchCount), 64'd2);
        step("f40", 0, 0, 0, 9'h000);
        chk("s3.ifpc_abs",  64'(IfIdPC),    64'h040);
        chk("s3.word_abs",  64'(IfIdInstr), 64'hAAAA0040);
        step("f44", 0, 0, 0, 9'h000);

        // PC wrap from 0x1FC
        step("br1fc", 0, 0, 1, 9'h1FC);
        step("f1fc", 0, 0, 0, 9'h000);
        chk("s5.pc_abs",    64'(PCAddress), 64'h000);
        chk("s5.ifpc_abs",  64'(IfIdPC),    64'h1FC);
        chk("s5.fault_abs", 64'(Fault),     64'h0);
        step("f000", 0, 0, 0, 9'h000);

        // Misaligned branch halts; later branches and stalls are ignored
        step("br42", 0, 0, 1, 9'h042);
        chk("s4.fault_abs", 64'(Fault),     64'h1);
        chk("s4.pc_abs",    64'(PCAddress), 64'h004);
        step("halt_br", 0, 0, 1, 9'h080);
        step("halt_st", 0, 1, 0, 9'h000);
        step("halt_run", 0, 0, 0, 9'h000);
        chk("s4.pc_hold", 64'(PCAddress), 64'h004);

        // Reset in HALT
        step("rst_halt", 1, 1, 1, 9'h042);
        chk_reset_values("rst_halt_abs");
        step("boot2", 0, 0, 0, 9'h000);
        for (int i = 0; i < 3; i++) step("run2", 0, 0, 0, 9'h000);

        // Reset in the middle of a stall
        step("stall2", 0, 1, 0, 9'h000);
        step("rst_stall", 1, 1, 0, 9'h000);
        chk_reset_values("rst_stall_abs");

        // Reset coinciding with a redirect request
        step("boot3", 0, 0, 0, 9'h000);
        step("f0b", 0, 0, 0, 9'h000);
        step("rst_br", 1, 0, 1, 9'h100);
        chk_reset_values("rst_br_abs");

        // Randomised traffic with occasional resets
        for (int i = 0; i < 200; i++) begin
            logic       r;
            logic       s;
            logic       b;
            logic [8:0] t;
            r = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            step("rnd", r, s, b, t);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
